key_debounce_sync: RTL and testbench

//  Conditions the raw push-button inputs before they reach the keys_export PIO of the Nios II/FreeRTOS system.
//  - Synchronises each asynchronous key into clk_clk.
//  - Debounces each key with a per-key counter state machine.
//  - Drives a clean active-high "pressed" level onto keys_export, plus single-cycle press/release pulses.

---
 rtl/key_pkg.sv | 11 +
 rtl/key_debounce_ch.sv | 153 +++++++++++++++
 rtl/key_debounce_sync.sv | 36 +++
 tb/tb_key_debounce_sync.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the push-button conditioning block.
package key_pkg;

   typedef enum logic [1:0] {KEY_UP, KEY_PEND_DN, KEY_DOWN, KEY_PEND_UP} key_state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, registered level and pulses.
// Optional auto-repeat of the press pulse is built when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int              CNT_W    = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic            REL_RAW  = (ACTIVE_LOW != 0);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
   end

   logic       sync_p0;
   logic       sync_p1;
   logic       s;

   key_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             lvl_nx, prs_nx, rls_nx;

   // Synchroniser stage: holds the released raw level out of reset
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync_p0 <= REL_RAW;
         sync_p1 <= REL_RAW;
      end else begin
         sync_p0 <= key_raw;
         sync_p1 <= sync_p0;
      end
   end

   assign s = sync_p1 ^ REL_RAW;

`ifdef KEY_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = cnt_w(REP_MAX);
   localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
   logic             rep_arm, rep_arm_nx;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rep_cnt <= '0;
         rep_arm <= 1'b0;
      end else begin
         rep_cnt <= rep_cnt_nx;
         rep_arm <= rep_arm_nx;
      end
   end
`endif

   // FSM stage: state, debounce count and registered outputs
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state       <= KEY_UP;
         cnt         <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         key_level   <= lvl_nx;
         key_press   <= prs_nx;
         key_release <= rls_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      lvl_nx   = key_level;
      prs_nx   = 1'b0;
      rls_nx   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_nx = '0;
      rep_arm_nx = 1'b0;
`endif
      case (state)
         KEY_UP: begin
            if (s) begin
               state_nx = KEY_PEND_DN;
               cnt_nx   = '0;
            end
         end
         KEY_PEND_DN: begin
            if (!s) begin
               state_nx = KEY_UP;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = KEY_DOWN;
               cnt_nx   = '0;
               lvl_nx   = 1'b1;
               prs_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         KEY_DOWN: begin
            if (!s) begin
               state_nx = KEY_PEND_UP;
               cnt_nx   = '0;
            end
`ifdef KEY_AUTOREPEAT_EN
            // First repeat after the long delay, then at the shorter period
            else if ((!rep_arm && rep_cnt == REP_DLY_LAST) ||
                     ( rep_arm && rep_cnt == REP_PER_LAST)) begin
               prs_nx     = 1'b1;
               rep_cnt_nx = '0;
               rep_arm_nx = 1'b1;
            end else begin
               rep_cnt_nx = rep_cnt + 1'b1;
               rep_arm_nx = rep_arm;
            end
`endif
         end
         KEY_PEND_UP: begin
            if (s) begin
               state_nx = KEY_DOWN;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = KEY_UP;
               cnt_nx   = '0;
               lvl_nx   = 1'b0;
               rls_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = KEY_UP;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce_sync.sv
// Push-button conditioner: NUM_KEYS independent synchronise/debounce channels.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce_sync
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] keys_export,
   output logic [NUM_KEYS-1:0] key_press_pulse,
   output logic [NUM_KEYS-1:0] key_release_pulse
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk_clk     (clk_clk),
         .reset_reset (reset_reset),
         .key_raw     (key_raw[i]),
         .key_level   (keys_export[i]),
         .key_press   (key_press_pulse[i]),
         .key_release (key_release_pulse[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_key_debounce_sync;

   logic       clk_clk = 1'b0;
   logic       reset_reset;
   logic [3:0] key_raw;
   logic [3:0] keys_export;
   logic [3:0] key_press_pulse;
   logic [3:0] key_release_pulse;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_clk = ~clk_clk;

   key_debounce_sync #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (8),
      .ACTIVE_LOW      (1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk_clk           (clk_clk),
      .reset_reset       (reset_reset),
      .key_raw           (key_raw),
      .keys_export       (keys_export),
      .key_press_pulse   (key_press_pulse),
      .key_release_pulse (key_release_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (level/press/release nibbles)", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   function automatic logic [31:0] outs();
      return {20'd0, keys_export, key_press_pulse, key_release_pulse};
   endfunction

   function automatic logic [31:0] ex(input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
      return {20'd0, l, p, r};
   endfunction

   logic rep;

   initial begin
      reset_reset = 1'b1;
      key_raw     = 4'hF;

      // 1. reset and idle
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_hold", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      reset_reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("idle", outs(), ex(4'h0, 4'h0, 4'h0));
      end

      // 2. clean press of key 0, held for repeat check, then released
      key_raw = 4'hE;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("press0_wait", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      tick();
      chk("press0_accept", outs(), ex(4'h1, 4'h1, 4'h0));
      for (int j = 1; j <= 32; j++) begin
         tick();
`ifdef KEY_AUTOREPEAT_EN
         rep = (j == 20) || (j == 25) || (j == 30);
`else
         rep = 1'b0;
`endif
         chk("hold0", outs(), ex(4'h1, {3'b000, rep}, 4'h0));
      end
      key_raw = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("release0_wait", outs(), ex(4'h1, 4'h0, 4'h0));
      end
      tick();
      chk("release0_accept", outs(), ex(4'h0, 4'h0, 4'h1));
      tick();
      chk("release0_after", outs(), ex(4'h0, 4'h0, 4'h0));

      // 3. bounce on key 1 never reaches the outputs
      for (int c = 0; c < 40; c++) begin
         key_raw[1] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
         tick();
         chk("bounce1", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      key_raw[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("bounce1_settle", outs(), ex(4'h0, 4'h0, 4'h0));
      end

      // 4. press then release key 2
      key_raw[2] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("press2_wait", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      tick();
      chk("press2_accept", outs(), ex(4'h4, 4'h4, 4'h0));
      tick();
      chk("press2_after", outs(), ex(4'h4, 4'h0, 4'h0));
      key_raw[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("release2_wait", outs(), ex(4'h4, 4'h0, 4'h0));
      end
      tick();
      chk("release2_accept", outs(), ex(4'h0, 4'h0, 4'h4));
      tick();
      chk("release2_after", outs(), ex(4'h0, 4'h0, 4'h0));

      // 5a. simultaneous keys 0 and 3
      key_raw = 4'h6;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("press03_wait", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      tick();
      chk("press03_accept", outs(), ex(4'h9, 4'h9, 4'h0));
      tick();
      chk("press03_after", outs(), ex(4'h9, 4'h0, 4'h0));
      key_raw = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("release03_wait", outs(), ex(4'h9, 4'h0, 4'h0));
      end
      tick();
      chk("release03_accept", outs(), ex(4'h0, 4'h0, 4'h9));
      tick();
      chk("release03_after", outs(), ex(4'h0, 4'h0, 4'h0));

      // 5b. reset at cnt=4 of PEND_DN on key 1, key held through reset
      key_raw = 4'hD;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("pend1_wait", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      reset_reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("rst_mid", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      reset_reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("held1_wait", outs(), ex(4'h0, 4'h0, 4'h0));
      end
      tick();
      chk("held1_accept", outs(), ex(4'h2, 4'h2, 4'h0));
      tick();
      chk("held1_after", outs(), ex(4'h2, 4'h0, 4'h0));
      key_raw = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("release1_wait", outs(), ex(4'h2, 4'h0, 4'h0));
      end
      tick();
      chk("release1_accept", outs(), ex(4'h0, 4'h0, 4'h2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
